hssl_vio_ctrl: RTL and testbench
================================

HSSL_VIO_CTRL -- requirements
Module: hssl_vio_ctrl

Interface
REQ-001 Parameter RST_PULSE_CYCLES, default 16: reset pulse length in clocks, range 1..255.
REQ-002 Parameter STABLE_CYCLES, default 1024: vio_loopback stability window in clocks, range 1..65535.
REQ-003 Port hsslif_clk  in  1: sole clock; VIO probe outputs are synchronous to it.
REQ-004 Port hsslif_reset  in  1: reset; synchronous, active-high.
REQ-005 Ports vio_reset_all, vio_reset_tx, vio_reset_rx  in  1 each: VIO level requests; each rising edge requests a reset.
REQ-006 Port vio_clr_cnt  in  1: VIO level; a rising edge requests a counter clear.
REQ-007 Port vio_stop  in  1: VIO level; link-halt request.
REQ-008 Port vio_loopback  in  3: requested GTH loopback code.
REQ-009 Ports gth_reset_all, gth_reset_tx, gth_reset_rx  out  1 each: stretched resets to the GTH block.
REQ-010 Port cnt_clear  out  1: single-cycle clear pulse to the status counters.
REQ-011 Port hssl_stop  out  1: registered halt level.
REQ-012 Port gth_loopback  out  3: applied loopback code.
REQ-013 Port busy  out  1: high whenever the FSM is not in IDLE.

Function
REQ-014 Edge detect: edge at cycle N when input=1 at N and previous=0; previous registers reset to 1 so levels already high at reset exit produce no edge.
REQ-015 cnt_clear shall be high for exactly cycle N+1 after a vio_clr_cnt edge at N, independent of FSM state.
REQ-016 hssl_stop shall equal vio_stop delayed by one cycle.
REQ-017 FSM states: IDLE, PULSE, LB_WAIT, LB_APPLY.
REQ-018 PULSE drives the selected reset output(s) high for exactly RST_PULSE_CYCLES consecutive cycles, starting the cycle after the edge, then returns to IDLE.
REQ-019 vio_reset_all edge in any state aborts the current state, discards pending tx/rx requests, enters PULSE with all three reset outputs high, and restarts the count.
REQ-020 vio_reset_tx/rx edge in IDLE or LB_WAIT enters PULSE with the matching output(s); edges arriving in the same cycle pulse together.
REQ-021 tx/rx edges in PULSE or LB_APPLY are latched as pending and served on the first IDLE cycle; repeated edges collapse to one pending request.
REQ-022 IDLE enters LB_WAIT when vio_loopback != gth_loopback and no reset is pending.
REQ-023 LB_WAIT restarts its counter on any vio_loopback change; it returns to IDLE if vio_loopback equals gth_loopback; after STABLE_CYCLES unchanged cycles it enters LB_APPLY.
REQ-024 On LB_APPLY entry, gth_loopback takes vio_loopback and gth_reset_rx is held high for RST_PULSE_CYCLES cycles; the FSM then returns to IDLE.
REQ-025 Counters shall be sized as $clog2(param+1) bits and saturate; they never wrap.

Reset
REQ-026 While hsslif_reset=1: state IDLE; all gth_reset_* = 0; cnt_clear = 0; hssl_stop = 0; gth_loopback = 3'b000; busy = 0; pending flags cleared; counters = 0.
REQ-027 Reset mid-PULSE or mid-LB_APPLY shall drop the outputs in the next cycle; no request survives reset.

Configuration
REQ-028 With macro HSSL_VIO_CTRL_LOOPBACK_EN defined, loopback sequencing follows REQ-022..REQ-024.
REQ-029 Without HSSL_VIO_CTRL_LOOPBACK_EN, vio_loopback is ignored, gth_loopback is tied to 3'b000, and LB_WAIT and LB_APPLY are unreachable.

Structure
REQ-030 Package hssl_vio_pkg holds the FSM state enum and the loopback code constants: NORMAL 000, NE_PCS 001, NE_PMA 010, FE_PMA 100, FE_PCS 110.
REQ-031 The rising-edge detector is sub-module hssl_vio_edge_det (one-bit, reset-to-1 history), instanced per request input.

Verification
REQ-032 vio_reset_tx rises at cycle 10 -> gth_reset_tx high cycles 11..26, busy high 11..26, other resets low.
REQ-033 vio_reset_rx edge at cycle 15 during the TX pulse -> RX pulse begins the first IDLE cycle after 26 and lasts 16 cycles.
REQ-034 vio_reset_all edge at cycle 20 mid-TX pulse -> all three resets high cycles 21..36, pending RX discarded.
REQ-035 vio_loopback 000->010 at cycle 0 with a glitch to 011 at cycle 500, then back to 010 -> LB_APPLY only after 1024 stable cycles of 010; gth_loopback=010 and gth_reset_rx high for 16 cycles.
REQ-036 vio_clr_cnt held high across hsslif_reset deassertion -> no cnt_clear pulse; a later 0->1 edge -> exactly one one-cycle pulse.
REQ-037 Built without HSSL_VIO_CTRL_LOOPBACK_EN, vio_loopback=110 -> gth_loopback stays 000 and busy stays 0.

Source files
------------

// File: rtl/hssl_vio_pkg.sv
// hssl_vio_pkg
// Shared definitions for the HSSL VIO control slice: the controller FSM
// state encoding, the reset-select bundle and the GTH loopback codes.
package hssl_vio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PULSE    = 2'd1,
        ST_LB_WAIT  = 2'd2,
        ST_LB_APPLY = 2'd3
    } state_t;

    // Which GTH reset outputs a PULSE drives.
    typedef struct packed {
        logic all;
        logic tx;
        logic rx;
    } rst_sel_t;

    // GTH loopback codes.
    localparam logic [2:0] LB_NORMAL = 3'b000;
    localparam logic [2:0] LB_NE_PCS = 3'b001;
    localparam logic [2:0] LB_NE_PMA = 3'b010;
    localparam logic [2:0] LB_FE_PMA = 3'b100;
    localparam logic [2:0] LB_FE_PCS = 3'b110;

endpackage

// File: rtl/hssl_vio_edge_det.sv
// hssl_vio_edge_det
// One-bit rising-edge detector for a VIO request level.
// The history register resets to 1, so a level that is already high when
// reset is released does not count as an edge.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   din  - level input (synchronous to clk)
//   rise - high in the cycle where din=1 and the previous sample was 0
module hssl_vio_edge_det
    import hssl_vio_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b1;
        end else begin
            prev <= din;
        end
    end

    assign rise = din & ~prev;

endmodule

// File: rtl/hssl_vio_ctrl.sv
// hssl_vio_ctrl
// Turns VIO probe levels into GTH control: stretched reset pulses, a
// one-cycle status-counter clear, a registered halt level and (optionally)
// debounced loopback-code changes that are followed by an RX reset pulse.
//
// Optional feature: define HSSL_VIO_CTRL_LOOPBACK_EN to enable loopback
// sequencing. Without it vio_loopback is ignored, gth_loopback is 3'b000
// and the FSM never leaves IDLE/PULSE.
//
// Parameters:
//   RST_PULSE_CYCLES - reset pulse length in clocks (1..255)
//   STABLE_CYCLES    - loopback stability window in clocks (1..65535)
// Ports:
//   hsslif_clk       - sole clock
//   hsslif_reset     - synchronous active-high reset
//   vio_reset_all/tx/rx - reset request levels (rising edge = request)
//   vio_clr_cnt      - counter clear request level (rising edge = request)
//   vio_stop         - link halt level
//   vio_loopback     - requested loopback code
//   gth_reset_all/tx/rx - stretched resets to the GTH
//   cnt_clear        - one-cycle clear pulse to status counters
//   hssl_stop        - vio_stop delayed one cycle
//   gth_loopback     - applied loopback code
//   busy             - FSM not in IDLE
module hssl_vio_ctrl
    import hssl_vio_pkg::*;
#(
    parameter int RST_PULSE_CYCLES = 16,
    parameter int STABLE_CYCLES    = 1024
) (
    input  logic       hsslif_clk,
    input  logic       hsslif_reset,
    input  logic       vio_reset_all,
    input  logic       vio_reset_tx,
    input  logic       vio_reset_rx,
    input  logic       vio_clr_cnt,
    input  logic       vio_stop,
    input  logic [2:0] vio_loopback,
    output logic       gth_reset_all,
    output logic       gth_reset_tx,
    output logic       gth_reset_rx,
    output logic       cnt_clear,
    output logic       hssl_stop,
    output logic [2:0] gth_loopback,
    output logic       busy
);

    localparam int PW = $clog2(RST_PULSE_CYCLES + 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_MAX  = PW'(RST_PULSE_CYCLES);

    function automatic logic [PW-1:0] pulse_inc(input logic [PW-1:0] v);
        if (v >= PULSE_MAX) begin
            return v;
        end
        return v + PW'(1);
    endfunction

`ifdef HSSL_VIO_CTRL_LOOPBACK_EN
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_MAX  = SW'(STABLE_CYCLES);

    function automatic logic [SW-1:0] stable_inc(input logic [SW-1:0] v);
        if (v >= STABLE_MAX) begin
            return v;
        end
        return v + SW'(1);
    endfunction
`endif

    // ------------------------------------------------------------------
    // Request edge detection
    // ------------------------------------------------------------------
    logic rise_all, rise_tx, rise_rx, rise_clr;

    hssl_vio_edge_det u_edge_all (
        .clk (hsslif_clk), .rst (hsslif_reset), .din (vio_reset_all), .rise (rise_all)
    );
    hssl_vio_edge_det u_edge_tx (
        .clk (hsslif_clk), .rst (hsslif_reset), .din (vio_reset_tx), .rise (rise_tx)
    );
    hssl_vio_edge_det u_edge_rx (
        .clk (hsslif_clk), .rst (hsslif_reset), .din (vio_reset_rx), .rise (rise_rx)
    );
    hssl_vio_edge_det u_edge_clr (
        .clk (hsslif_clk), .rst (hsslif_reset), .din (vio_clr_cnt), .rise (rise_clr)
    );

    // Counter clear and halt are independent of the FSM.
    always_ff @(posedge hsslif_clk) begin
        if (hsslif_reset) begin
            cnt_clear <= 1'b0;
            hssl_stop <= 1'b0;
        end else begin
            cnt_clear <= rise_clr;
            hssl_stop <= vio_stop;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_t         state, state_nxt;
    logic [PW-1:0]  pcnt, pcnt_nxt;
    rst_sel_t       sel, sel_nxt;
    logic           pend_tx, pend_tx_nxt;
    logic           pend_rx, pend_rx_nxt;

`ifdef HSSL_VIO_CTRL_LOOPBACK_EN
    logic [SW-1:0]  scnt, scnt_nxt;
    logic [2:0]     lb_code, lb_code_nxt;
    logic [2:0]     lb_target, lb_target_nxt;
`else
    logic           unused_lb;
    assign unused_lb = ^vio_loopback;
`endif

    always_comb begin
        state_nxt   = state;
        pcnt_nxt    = pcnt;
        sel_nxt     = sel;
        pend_tx_nxt = pend_tx;
        pend_rx_nxt = pend_rx;
`ifdef HSSL_VIO_CTRL_LOOPBACK_EN
        scnt_nxt      = scnt;
        lb_code_nxt   = lb_code;
        lb_target_nxt = lb_target;
`endif

        if (rise_all) begin
            // A full reset overrides everything, including queued requests.
            state_nxt   = ST_PULSE;
            pcnt_nxt    = '0;
            sel_nxt.all = 1'b1;
            sel_nxt.tx  = 1'b1;
            sel_nxt.rx  = 1'b1;
            pend_tx_nxt = 1'b0;
            pend_rx_nxt = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rise_tx || rise_rx || pend_tx || pend_rx) begin
                        state_nxt   = ST_PULSE;
                        pcnt_nxt    = '0;
                        sel_nxt.all = 1'b0;
                        sel_nxt.tx  = rise_tx | pend_tx;
                        sel_nxt.rx  = rise_rx | pend_rx;
                        pend_tx_nxt = 1'b0;
                        pend_rx_nxt = 1'b0;
                    end
`ifdef HSSL_VIO_CTRL_LOOPBACK_EN
                    else if (vio_loopback != lb_code) begin
                        state_nxt     = ST_LB_WAIT;
                        scnt_nxt      = '0;
                        lb_target_nxt = vio_loopback;
                    end
`endif
                end

                ST_PULSE: begin
                    pend_tx_nxt = pend_tx | rise_tx;
                    pend_rx_nxt = pend_rx | rise_rx;
                    if (pcnt == PULSE_LAST) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        pcnt_nxt = pulse_inc(pcnt);
                    end
                end

`ifdef HSSL_VIO_CTRL_LOOPBACK_EN
                ST_LB_WAIT: begin
                    if (rise_tx || rise_rx) begin
                        state_nxt   = ST_PULSE;
                        pcnt_nxt    = '0;
                        sel_nxt.all = 1'b0;
                        sel_nxt.tx  = rise_tx;
                        sel_nxt.rx  = rise_rx;
                    end else if (vio_loopback == lb_code) begin
                        state_nxt = ST_IDLE;
                    end else if (vio_loopback != lb_target) begin
                        // Any change restarts the stability window.
                        lb_target_nxt = vio_loopback;
                        scnt_nxt      = '0;
                    end else if (scnt == STABLE_LAST) begin
                        state_nxt   = ST_LB_APPLY;
                        pcnt_nxt    = '0;
                        lb_code_nxt = vio_loopback;
                    end else begin
                        scnt_nxt = stable_inc(scnt);
                    end
                end

                ST_LB_APPLY: begin
                    pend_tx_nxt = pend_tx | rise_tx;
                    pend_rx_nxt = pend_rx | rise_rx;
                    if (pcnt == PULSE_LAST) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        pcnt_nxt = pulse_inc(pcnt);
                    end
                end
`endif

                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge hsslif_clk) begin
        if (hsslif_reset) begin
            state   <= ST_IDLE;
            pcnt    <= '0;
            sel     <= '0;
            pend_tx <= 1'b0;
            pend_rx <= 1'b0;
`ifdef HSSL_VIO_CTRL_LOOPBACK_EN
            scnt    <= '0;
            lb_code <= LB_NORMAL;
`endif
        end else begin
            state   <= state_nxt;
            pcnt    <= pcnt_nxt;
            sel     <= sel_nxt;
            pend_tx <= pend_tx_nxt;
            pend_rx <= pend_rx_nxt;
`ifdef HSSL_VIO_CTRL_LOOPBACK_EN
            scnt    <= scnt_nxt;
            lb_code <= lb_code_nxt;
`endif
        end
    end

`ifdef HSSL_VIO_CTRL_LOOPBACK_EN
    // Comparison target only; its value is irrelevant outside LB_WAIT.
    always_ff @(posedge hsslif_clk) begin
        lb_target <= lb_target_nxt;
    end

    assign gth_loopback = lb_code;
`else
    assign gth_loopback = LB_NORMAL;
`endif

    // ------------------------------------------------------------------
    // Outputs decoded from registered state
    // ------------------------------------------------------------------
    assign busy          = (state != ST_IDLE);
    assign gth_reset_all = (state == ST_PULSE) & sel.all;
    assign gth_reset_tx  = (state == ST_PULSE) & sel.tx;
    assign gth_reset_rx  = ((state == ST_PULSE) & sel.rx) | (state == ST_LB_APPLY);

endmodule

// File: tb/tb_hssl_vio_ctrl.sv
// tb_hssl_vio_ctrl
// Directed bench for hssl_vio_ctrl with a behavioural reference model and a
// per-cycle compare process, plus literal expectations at key cycles.
// Cycle numbering: after reset release "cycle 0" begins; inputs driven in
// cycle N are sampled at the end of cycle N, registered effects show in N+1.
module tb_hssl_vio_ctrl;

    localparam int R = 16;
    localparam int S = 1024;
`ifdef HSSL_VIO_CTRL_LOOPBACK_EN
    localparam bit LB_EN = 1'b1;
`else
    localparam bit LB_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       v_all, v_tx, v_rx, v_clr, v_stop;
    logic [2:0] v_lb;
    logic       o_all, o_tx, o_rx, o_clr, o_stop, o_busy;
    logic [2:0] o_lb;

    int total = 0;
    int bad   = 0;
    int rel   = 0;

    always #5 clk = ~clk;

    hssl_vio_ctrl #(
        .RST_PULSE_CYCLES (R),
        .STABLE_CYCLES    (S)
    ) dut (
        .hsslif_clk    (clk),
        .hsslif_reset  (rst),
        .vio_reset_all (v_all),
        .vio_reset_tx  (v_tx),
        .vio_reset_rx  (v_rx),
        .vio_clr_cnt   (v_clr),
        .vio_stop      (v_stop),
        .vio_loopback  (v_lb),
        .gth_reset_all (o_all),
        .gth_reset_tx  (o_tx),
        .gth_reset_rx  (o_rx),
        .cnt_clear     (o_clr),
        .hssl_stop     (o_stop),
        .gth_loopback  (o_lb),
        .busy          (o_busy)
    );

    task automatic chk(input string name, input logic [2:0] got, input logic [2:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad < 40)
                $display("FAIL %s at t=%0t: got=%0h want=%0h", name, $time, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: remaining-pulse countdown, request queue, run length
    // ------------------------------------------------------------------
    bit         armed = 1'b0;
    bit         p_all, p_tx, p_rx, p_clr;
    bit         e_all, e_tx, e_rx, e_clr;
    int         left;
    bit [2:0]   mask;       // {all, tx, rx} driven while left > 0
    bit         q_tx, q_rx;
    bit         waiting;
    int         run;
    logic [2:0] want, applied;
    bit         x_clr, x_stop;

    always @(posedge clk) begin
        if (rst) begin
            armed = 1'b1;
            p_all = 1'b1; p_tx = 1'b1; p_rx = 1'b1; p_clr = 1'b1;
            left = 0; mask = 3'b000; q_tx = 1'b0; q_rx = 1'b0;
            waiting = 1'b0; run = 0; want = 3'b000; applied = 3'b000;
            x_clr = 1'b0; x_stop = 1'b0;
        end else begin
            e_all = v_all & ~p_all;
            e_tx  = v_tx  & ~p_tx;
            e_rx  = v_rx  & ~p_rx;
            e_clr = v_clr & ~p_clr;
            p_all = v_all; p_tx = v_tx; p_rx = v_rx; p_clr = v_clr;
            x_clr  = e_clr;
            x_stop = v_stop;
            if (e_all) begin
                left = R; mask = 3'b111; waiting = 1'b0; q_tx = 1'b0; q_rx = 1'b0;
            end else if (left > 0) begin
                q_tx = q_tx | e_tx;
                q_rx = q_rx | e_rx;
                left = left - 1;
            end else if (waiting) begin
                if (e_tx || e_rx) begin
                    left = R; mask = {1'b0, e_tx, e_rx}; waiting = 1'b0;
                end else if (v_lb == applied) begin
                    waiting = 1'b0;
                end else if (v_lb != want) begin
                    want = v_lb; run = 0;
                end else begin
                    run = run + 1;
                    if (run == S) begin
                        applied = v_lb; left = R; mask = 3'b001; waiting = 1'b0;
                    end
                end
            end else begin
                if (e_tx || e_rx || q_tx || q_rx) begin
                    left = R; mask = {1'b0, e_tx | q_tx, e_rx | q_rx};
                    q_tx = 1'b0; q_rx = 1'b0;
                end else if (LB_EN && (v_lb != applied)) begin
                    waiting = 1'b1; want = v_lb; run = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("m_reset_all", {2'b0, o_all}, {2'b0, (left > 0) & mask[2]});
            chk("m_reset_tx",  {2'b0, o_tx},  {2'b0, (left > 0) & mask[1]});
            chk("m_reset_rx",  {2'b0, o_rx},  {2'b0, (left > 0) & mask[0]});
            chk("m_cnt_clear", {2'b0, o_clr}, {2'b0, x_clr});
            chk("m_hssl_stop", {2'b0, o_stop},{2'b0, x_stop});
            chk("m_busy",      {2'b0, o_busy},{2'b0, (left > 0) | waiting});
            chk("m_loopback",  o_lb, applied);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic go(input int n);
        while (rel < n) begin
            @(posedge clk);
            #1;
            rel++;
        end
    endtask

    task automatic clear_in();
        v_all = 1'b0; v_tx = 1'b0; v_rx = 1'b0;
        v_clr = 1'b0; v_stop = 1'b0; v_lb = 3'b000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        rel = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_in();

        // TX reset alone: pulse cycles 11..26
        do_reset();
        chk("rst_busy", {2'b0, o_busy}, 3'd0);
        chk("rst_lb", o_lb, 3'b000);
        go(10); chk("a_tx10", {2'b0, o_tx}, 3'd0); v_tx = 1'b1;
        go(11); chk("a_tx11", {2'b0, o_tx}, 3'd1); chk("a_busy11", {2'b0, o_busy}, 3'd1);
                chk("a_rx11", {2'b0, o_rx}, 3'd0); chk("a_all11", {2'b0, o_all}, 3'd0);
        go(26); chk("a_tx26", {2'b0, o_tx}, 3'd1);
        go(27); chk("a_tx27", {2'b0, o_tx}, 3'd0); chk("a_busy27", {2'b0, o_busy}, 3'd0);

        // RX edge during TX pulse: served from IDLE at 27, pulse 28..43
        clear_in(); do_reset();
        go(10); v_tx = 1'b1;
        go(15); v_rx = 1'b1;
        go(27); chk("b_rx27", {2'b0, o_rx}, 3'd0); chk("b_busy27", {2'b0, o_busy}, 3'd0);
        go(28); chk("b_rx28", {2'b0, o_rx}, 3'd1); chk("b_tx28", {2'b0, o_tx}, 3'd0);
        go(43); chk("b_rx43", {2'b0, o_rx}, 3'd1);
        go(44); chk("b_rx44", {2'b0, o_rx}, 3'd0);

        // Reset-all mid TX pulse: all high 21..36, pending RX dropped
        clear_in(); do_reset();
        go(10); v_tx = 1'b1;
        go(15); v_rx = 1'b1;
        go(20); chk("c_all20", {2'b0, o_all}, 3'd0); v_all = 1'b1;
        go(21); chk("c_res21", {o_all, o_tx, o_rx}, 3'b111);
        go(36); chk("c_res36", {o_all, o_tx, o_rx}, 3'b111);
        go(37); chk("c_res37", {o_all, o_tx, o_rx}, 3'b000); chk("c_busy37", {2'b0, o_busy}, 3'd0);
        go(38); chk("c_rx38", {2'b0, o_rx}, 3'd0); chk("c_busy38", {2'b0, o_busy}, 3'd0);

        // Simultaneous TX and RX edges pulse together
        clear_in(); do_reset();
        go(5); v_tx = 1'b1; v_rx = 1'b1;
        go(6);  chk("f_res6",  {o_all, o_tx, o_rx}, 3'b011);
        go(21); chk("f_res21", {o_all, o_tx, o_rx}, 3'b011);
        go(22); chk("f_res22", {o_all, o_tx, o_rx}, 3'b000);

        // Clear held across reset, later edge; stop delay; reset mid-pulse
        clear_in(); v_clr = 1'b1; do_reset();
        go(1); chk("d_clr1", {2'b0, o_clr}, 3'd0);
        go(2); chk("d_clr2", {2'b0, o_clr}, 3'd0);
        go(3); chk("d_stop3", {2'b0, o_stop}, 3'd0); v_stop = 1'b1;
        go(4); chk("d_stop4", {2'b0, o_stop}, 3'd1);
        go(5); v_clr = 1'b0;
        go(8); chk("d_clr8", {2'b0, o_clr}, 3'd0); v_clr = 1'b1;
        go(9); chk("d_clr9", {2'b0, o_clr}, 3'd1);
        go(10); chk("d_clr10", {2'b0, o_clr}, 3'd0);
        go(12); v_tx = 1'b1;
        go(13); chk("d_tx13", {2'b0, o_tx}, 3'd1);
        go(16); rst = 1'b1;
        go(17); chk("d_tx17", {2'b0, o_tx}, 3'd0); chk("d_busy17", {2'b0, o_busy}, 3'd0);
        do_reset();
        go(3); chk("d_tx_after", {2'b0, o_tx}, 3'd0); chk("d_busy_after", {2'b0, o_busy}, 3'd0);

        // Loopback change with a one-cycle glitch at 500
        clear_in(); v_lb = 3'b010; do_reset();
        go(100); chk("e_busy100", {2'b0, o_busy}, {2'b0, LB_EN});
        go(500); v_lb = 3'b011;
        go(501); v_lb = 3'b010;
        go(1525); chk("e_lb1525", o_lb, 3'b000);
        go(1526); chk("e_lb1526", o_lb, LB_EN ? 3'b010 : 3'b000);
                  chk("e_rx1526", {2'b0, o_rx}, {2'b0, LB_EN});
        go(1541); chk("e_rx1541", {2'b0, o_rx}, {2'b0, LB_EN});
        go(1542); chk("e_rx1542", {2'b0, o_rx}, 3'd0); chk("e_busy1542", {2'b0, o_busy}, 3'd0);
        go(1550);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
